l2_port_arbiter: RTL
====================

Name: l2_port_arbiter

Overview:
- Shares the single L2 request port between the icache and the dcache.
- Each requester uses the same L2 handshake the dcache already drives: address, type, valid and store word out; fetched word and fetched-valid back.
- The grant is held for a full line burst (or until the owner goes idle), so refill and writeback beats from one cache are never interleaved with the other's.
- Sits between the two L1 caches and the L2.

Parameters:
- LINE_SIZE, 32: bytes per cache line.
- XLEN, 32: address and data width in bits.
- BEATS_PER_LINE, LINE_SIZE/(XLEN/8): localparam; word beats per line (8 by default).

Ports:
- clk  in  1  clock
- reset  in  1  async active-low reset
- ic_req_address  in  XLEN  icache L2 request address
- ic_req_type  in  memory_operation_e  icache request type
- ic_req_valid  in  1  icache request valid
- ic_word_to_store  in  XLEN  icache store data
- ic_fetched_word  out  XLEN  L2 data returned to the icache
- ic_fetched_word_valid  out  1  icache response strobe
- dc_req_address  in  XLEN  dcache L2 request address
- dc_req_type  in  memory_operation_e  dcache request type
- dc_req_valid  in  1  dcache request valid
- dc_word_to_store  in  XLEN  dcache store data
- dc_fetched_word  out  XLEN  L2 data returned to the dcache
- dc_fetched_word_valid  out  1  dcache response strobe
- l2_req_address  out  XLEN  muxed address to L2
- l2_req_type  out  memory_operation_e  muxed type to L2
- l2_req_valid  out  1  muxed valid to L2
- l2_word_to_store  out  XLEN  muxed store data to L2
- l2_fetched_word  in  XLEN  L2 response data
- l2_fetched_word_valid  in  1  L2 response strobe; completes one beat
- arb_owner  out  2  current owner: 00 none, 01 icache, 10 dcache

Behaviour:
- Clocking and reset:
  - One clock: clk.
  - reset is asynchronous and active-low; assertion takes effect immediately, with no clock edge required.
- Values while reset is asserted:
  - state IDLE, beat counter 0, pending 0, arb_owner 00.
  - All l2_* outputs 0; l2_req_type is '0.
  - Both *_fetched_word_valid outputs 0.
- Handshake:
  - A requester holds valid, address, type and store data stable until it sees its fetched_word_valid pulse.
  - If valid is still high in the cycle after that pulse, it is a new beat.
- State machine (states IDLE, OWN_IC, OWN_DC):
  - IDLE: all l2_* outputs 0.
    - If any requester's valid is high, pick a winner and move to OWN_x on the next edge.
    - Arbitration bubble: exactly 1 cycle from first valid to l2_req_valid.
  - OWN_x: l2_req_* is a combinational copy of requester x's request.
    - x_fetched_word_valid = l2_fetched_word_valid.
    - The non-owner's fetched_word_valid is forced 0.
    - Both *_fetched_word outputs always carry l2_fetched_word.
- pending flag:
  - Set on any cycle with l2_req_valid=1 and l2_fetched_word_valid=0.
  - Cleared on l2_fetched_word_valid.
- Beat counter ($clog2(BEATS_PER_LINE+1) bits):
  - Increments on each l2_fetched_word_valid while owned.
  - Cleared when entering IDLE.
- Release to IDLE (next edge) on either condition:
  - l2_fetched_word_valid arrives and the counter equals BEATS_PER_LINE-1 (the last beat of the burst).
  - The owner's valid is low while pending=0.
- Owner drops valid with pending=1 (protocol violation): ownership is held until the L2 response arrives. That response is still routed to the owner, then the grant is released.
- Release always passes through IDLE; there is no direct handoff between owners.
- Fixed priority (default): on a tie in IDLE, the dcache wins. Icache starvation is permitted.
- A response while in IDLE is dropped: both fetched_word_valid outputs stay 0.

Optional Feature:
- Macro: L2_ARB_ROUND_ROBIN_EN.
- When defined:
  - A last_owner register (reset value: icache) is updated on every grant.
  - A tie in IDLE goes to the requester that is not last_owner, so the first tie after reset goes to the dcache.
- When undefined: fixed dcache priority as above, and no last_owner register exists.

Test Plan:
- Single dcache burst: dc_req_valid held with address 0x0000_0100, L2 responding 2 cycles after each request -> l2_req_valid rises 1 cycle after dc_req_valid; 8 dc_fetched_word_valid pulses; arb_owner returns to 00 after the 8th beat; ic_fetched_word_valid stays 0 throughout.
- Contention, fixed priority: ic_req_valid and dc_req_valid rise in the same cycle -> arb_owner=10 first, the full 8-beat dcache burst completes, 1-cycle IDLE, then arb_owner=01.
- Round-robin, with L2_ARB_ROUND_ROBIN_EN: two back-to-back simultaneous contentions -> grant order is dcache, icache, dcache, icache.
- Early release: icache does 1 beat to 0x0000_2000, then drops valid -> release to IDLE after that beat; counter returns to 0.
- Mid-burst reset: reset asserted low after beat 3 of a dcache burst -> l2_req_valid and arb_owner go to 0 immediately, without waiting for a clock edge; after reset deasserts, a new request sees a full 8-beat burst.
- Response routing: l2_fetched_word=0xDEAD_BEEF while OWN_DC -> dc_fetched_word_valid=1, ic_fetched_word_valid=0, and both *_fetched_word outputs = 0xDEAD_BEEF.

Source files
------------

// File: rtl/l2_port_arbiter.sv
// l2_port_arbiter: shares the single L2 request port between the icache and the dcache,
// holding each grant for a full line burst. Define L2_ARB_ROUND_ROBIN_EN for round-robin ties.
package l2_arb_pkg;

    typedef enum logic [1:0] {
        MEM_OP_NONE  = 2'b00,
        MEM_OP_READ  = 2'b01,
        MEM_OP_WRITE = 2'b10,
        MEM_OP_FLUSH = 2'b11
    } memory_operation_e;

endpackage

module l2_port_arbiter
    import l2_arb_pkg::*;
#(
    parameter int unsigned LINE_SIZE = 32,
    parameter int unsigned XLEN      = 32
) (
    input  logic              clk,
    input  logic              reset,

    input  logic [XLEN-1:0]   ic_req_address,
    input  memory_operation_e ic_req_type,
    input  logic              ic_req_valid,
    input  logic [XLEN-1:0]   ic_word_to_store,
    output logic [XLEN-1:0]   ic_fetched_word,
    output logic              ic_fetched_word_valid,

    input  logic [XLEN-1:0]   dc_req_address,
    input  memory_operation_e dc_req_type,
    input  logic              dc_req_valid,
    input  logic [XLEN-1:0]   dc_word_to_store,
    output logic [XLEN-1:0]   dc_fetched_word,
    output logic              dc_fetched_word_valid,

    output logic [XLEN-1:0]   l2_req_address,
    output memory_operation_e l2_req_type,
    output logic              l2_req_valid,
    output logic [XLEN-1:0]   l2_word_to_store,
    input  logic [XLEN-1:0]   l2_fetched_word,
    input  logic              l2_fetched_word_valid,

    output logic [1:0]        arb_owner
);

    localparam int unsigned BEATS_PER_LINE = LINE_SIZE / (XLEN / 8);
    localparam int unsigned CNT_W          = $clog2(BEATS_PER_LINE + 1);

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS_PER_LINE - 1);

    // State encoding doubles as the arb_owner code.
    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] OWN_IC = 2'b01;
    localparam logic [1:0] OWN_DC = 2'b10;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic             pending_q, pending_d;

    logic             owner_valid;
    logic             last_beat;
    logic             release_grant;
    logic [1:0]       winner;

    // ------------------------------------------------------------------
    // Arbitration between simultaneous requests in IDLE
    // ------------------------------------------------------------------
`ifdef L2_ARB_ROUND_ROBIN_EN
    logic last_owner_q, last_owner_d;  // 1: dcache held the last grant

    always_comb begin
        winner = IDLE;
        if (ic_req_valid && dc_req_valid) begin
            winner = last_owner_q ? OWN_IC : OWN_DC;
        end else if (dc_req_valid) begin
            winner = OWN_DC;
        end else if (ic_req_valid) begin
            winner = OWN_IC;
        end
    end

    always_comb begin
        last_owner_d = last_owner_q;
        if (state_q == IDLE && winner != IDLE) begin
            last_owner_d = (winner == OWN_DC);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_owner_q <= 1'b0;
        end else begin
            last_owner_q <= last_owner_d;
        end
    end
`else
    always_comb begin
        winner = IDLE;
        if (dc_req_valid) begin
            winner = OWN_DC;
        end else if (ic_req_valid) begin
            winner = OWN_IC;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Ownership state machine
    // ------------------------------------------------------------------
    always_comb begin
        owner_valid = 1'b0;
        case (state_q)
            OWN_IC:  owner_valid = ic_req_valid;
            OWN_DC:  owner_valid = dc_req_valid;
            default: owner_valid = 1'b0;
        endcase
    end

    assign last_beat = l2_fetched_word_valid && (beat_cnt_q == LAST_BEAT);
    // An owner that drops valid with a beat outstanding keeps the grant until the response lands.
    assign release_grant = last_beat || (!owner_valid && !pending_q);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:           state_d = winner;
            OWN_IC, OWN_DC: if (release_grant) state_d = IDLE;
            default:        state_d = IDLE;
        endcase
    end

    always_comb begin
        beat_cnt_d = beat_cnt_q;
        if (state_d == IDLE) begin
            beat_cnt_d = '0;
        end else if (state_q != IDLE && l2_fetched_word_valid) begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        pending_d = pending_q;
        if (l2_fetched_word_valid) begin
            pending_d = 1'b0;
        end else if (l2_req_valid) begin
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            beat_cnt_q <= '0;
            pending_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            pending_q  <= pending_d;
        end
    end

    // ------------------------------------------------------------------
    // Request mux and response routing
    // ------------------------------------------------------------------
    always_comb begin
        l2_req_address        = '0;
        l2_req_type           = memory_operation_e'('0);
        l2_req_valid          = 1'b0;
        l2_word_to_store      = '0;
        ic_fetched_word_valid = 1'b0;
        dc_fetched_word_valid = 1'b0;
        case (state_q)
            OWN_IC: begin
                l2_req_address        = ic_req_address;
                l2_req_type           = ic_req_type;
                l2_req_valid          = ic_req_valid;
                l2_word_to_store      = ic_word_to_store;
                ic_fetched_word_valid = l2_fetched_word_valid;
            end
            OWN_DC: begin
                l2_req_address        = dc_req_address;
                l2_req_type           = dc_req_type;
                l2_req_valid          = dc_req_valid;
                l2_word_to_store      = dc_word_to_store;
                dc_fetched_word_valid = l2_fetched_word_valid;
            end
            default: begin
                // responses arriving with no owner are dropped
            end
        endcase
    end

    assign ic_fetched_word = l2_fetched_word;
    assign dc_fetched_word = l2_fetched_word;
    assign arb_owner       = state_q;

endmodule
